// File: rtl/banco_registros_param.sv
// rtl/banco_registros_param.sv - parametrised two-read/one-write register bank with post-reset clear sequencer
//
// Purpose:
//   Register bank with DEPTH entries of DATA_W bits. Entry 0 reads as zero and
//   has no storage. After reset a clear sequencer zeroes one entry per cycle.
//   Ready goes high when the sweep completes. Only then are writes accepted and
//   read data exposed.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   reset          synchronous reset, active-high
//   ReadRegister1  read port 1 address
//   ReadRegister2  read port 2 address
//   ReadData1      read port 1 data (combinational)
//   ReadData2      read port 2 data (combinational)
//   WriteRegister  write address
//   WriteData      write data
//   RegWrite       write enable
//   Ready          high once the clear sequence has finished
//
// Build option:
//   BANCO_BYPASS_EN  when defined, a read of the address being written in the
//                    same cycle returns WriteData (write-through). Otherwise it
//                    returns the value stored before the edge.

module banco_registros_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic              Ready
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W is representable for the range check.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clear_idx;
    logic [ADDR_W-1:0] w_clear_idx_next;
    logic [DATA_W-1:0] r_mem [1:DEPTH-1];
    logic              w_ready;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_ready = (r_state == ST_RUN);

    // The enable is qualified so that a write to entry 0 or to an address at or above DEPTH is dropped.
    assign w_wr_en = w_ready && RegWrite && (WriteRegister != '0)
                     && ({1'b0, WriteRegister} < DEPTH_EXT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_CLEAR;
            r_clear_idx <= '0;
        end else begin
            r_state     <= w_state_next;
            r_clear_idx <= w_clear_idx_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_clear_idx_next = r_clear_idx;
        if (r_state == ST_CLEAR) begin
            if (r_clear_idx == LAST_IDX) begin
                w_state_next     = ST_RUN;
                w_clear_idx_next = '0;
            end else begin
                w_clear_idx_next = r_clear_idx + ADDR_W'(1);
            end
        end
    end

    // Reset does not touch the contents. The clear sweep that follows reset is what zeroes the entries.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (r_state == ST_CLEAR) begin
                    if (r_clear_idx == ADDR_W'(i)) begin
                        r_mem[i] <= '0;
                    end
                end else if (w_wr_en && (WriteRegister == ADDR_W'(i))) begin
                    r_mem[i] <= WriteData;
                end
            end
        end
    end

    // Address 0 and addresses at or above DEPTH never match an entry, so those reads stay 0.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (w_ready) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (ReadRegister1 == ADDR_W'(i)) begin
                    w_rd1 = r_mem[i];
                end
                if (ReadRegister2 == ADDR_W'(i)) begin
                    w_rd2 = r_mem[i];
                end
            end
        end
`ifdef BANCO_BYPASS_EN
        if (w_wr_en && (ReadRegister1 == WriteRegister)) begin
            w_rd1 = WriteData;
        end
        if (w_wr_en && (ReadRegister2 == WriteRegister)) begin
            w_rd2 = WriteData;
        end
`else
`endif
    end

    assign ReadData1 = w_rd1;
    assign ReadData2 = w_rd2;
    assign Ready     = w_ready;

endmodule
